// File: rtl/lc3_wb_ctrl_pkg.sv
// Shared types and helpers for the LC3 writeback controller: opcodes,
// writeback source encodings, FSM states and opcode classification.
package lc3_wb_ctrl_pkg;

   localparam int unsigned OPW  = 4;
   localparam int unsigned DRW  = 3;
   localparam int unsigned WCW  = 2;
   localparam int unsigned CNTW = 16;

   localparam logic [OPW-1:0] OP_BR   = 4'b0000;
   localparam logic [OPW-1:0] OP_ADD  = 4'b0001;
   localparam logic [OPW-1:0] OP_LD   = 4'b0010;
   localparam logic [OPW-1:0] OP_ST   = 4'b0011;
   localparam logic [OPW-1:0] OP_JSR  = 4'b0100;
   localparam logic [OPW-1:0] OP_AND  = 4'b0101;
   localparam logic [OPW-1:0] OP_LDR  = 4'b0110;
   localparam logic [OPW-1:0] OP_STR  = 4'b0111;
   localparam logic [OPW-1:0] OP_RTI  = 4'b1000;
   localparam logic [OPW-1:0] OP_NOT  = 4'b1001;
   localparam logic [OPW-1:0] OP_LDI  = 4'b1010;
   localparam logic [OPW-1:0] OP_STI  = 4'b1011;
   localparam logic [OPW-1:0] OP_JMP  = 4'b1100;
   localparam logic [OPW-1:0] OP_RES  = 4'b1101;
   localparam logic [OPW-1:0] OP_LEA  = 4'b1110;
   localparam logic [OPW-1:0] OP_TRAP = 4'b1111;

   localparam logic [WCW-1:0] WB_ALU = 2'd0;
   localparam logic [WCW-1:0] WB_MEM = 2'd1;
   localparam logic [WCW-1:0] WB_PC  = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE, S_EXEC, S_IND_RD, S_MEM_RD, S_MEM_WR, S_WB
   } state_e;

   typedef enum logic [2:0] {
      CLS_NONE, CLS_ALU, CLS_LEA, CLS_LOAD, CLS_LOAD_IND, CLS_STORE, CLS_STORE_IND
   } op_class_e;

   function automatic op_class_e classify(input logic [OPW-1:0] op);
      case (op)
         OP_ADD, OP_AND, OP_NOT:                        classify = CLS_ALU;
         OP_LEA:                                        classify = CLS_LEA;
         OP_LD, OP_LDR:                                 classify = CLS_LOAD;
         OP_LDI:                                        classify = CLS_LOAD_IND;
         OP_ST, OP_STR:                                 classify = CLS_STORE;
         OP_STI:                                        classify = CLS_STORE_IND;
         OP_BR, OP_JSR, OP_RTI, OP_JMP, OP_RES, OP_TRAP: classify = CLS_NONE;
         default:                                       classify = CLS_NONE;
      endcase
   endfunction

   function automatic logic [WCW-1:0] wb_source(input op_class_e cls);
      case (cls)
         CLS_ALU: wb_source = WB_ALU;
         CLS_LEA: wb_source = WB_PC;
         default: wb_source = WB_MEM;
      endcase
   endfunction

endpackage

// File: rtl/lc3_mem_wait_timer.sv
// Per-access memory wait counter; flags expiry on the last allowed cycle
// unless the ack arrives in that same cycle.
module lc3_mem_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic run,
   input  logic ack,
   output logic expired
);

   localparam int unsigned CW = 8;

   logic [CW-1:0] cnt;

   // Counts cycles already spent waiting in the current memory state.
   always_ff @(posedge clk) begin
      if (rst || start || ack) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = run && !ack && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/lc3_writeback_controller.sv
// LC3 writeback sequencer: runs execute latency and memory phases for one
// instruction at a time, then issues a single writeback strobe.
module lc3_writeback_controller
   import lc3_wb_ctrl_pkg::*;
#(
   parameter int unsigned EXEC_LAT    = 1,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [OPW-1:0]  opcode,
   input  logic [DRW-1:0]  dr_in,
   input  logic            mem_ack,
   output logic            mem_req,
   output logic            mem_we,
   output logic            mem_ind,
   output logic            enable_writeback,
   output logic [WCW-1:0]  w_control,
   output logic [DRW-1:0]  dr,
   output logic            mem_err,
   output logic [CNTW-1:0] wb_count
);

   localparam int unsigned EXW = 3;

   state_e         state;
   op_class_e      cls;
   op_class_e      acc_cls;
   logic [DRW-1:0] dr_lat;
   logic [EXW-1:0] exec_cnt;
   logic           in_mem;
   logic           mem_start;
   logic           timer_exp;

   assign instr_ready = (state == S_IDLE) && !rst;
   assign acc_cls     = classify(opcode);
   assign in_mem      = (state == S_IND_RD) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign mem_start   = instr_ready && instr_valid &&
                        ((acc_cls == CLS_LOAD) || (acc_cls == CLS_LOAD_IND) ||
                         (acc_cls == CLS_STORE) || (acc_cls == CLS_STORE_IND));

   lc3_mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (mem_start),
      .run     (in_mem),
      .ack     (mem_ack),
      .expired (timer_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= S_IDLE;
         cls              <= CLS_NONE;
         dr_lat           <= '0;
         exec_cnt         <= '0;
         mem_req          <= 1'b0;
         mem_we           <= 1'b0;
         mem_ind          <= 1'b0;
         enable_writeback <= 1'b0;
         w_control        <= WB_ALU;
         dr               <= '0;
         mem_err          <= 1'b0;
         wb_count         <= '0;
      end else begin
         enable_writeback <= 1'b0;
         mem_err          <= 1'b0;
         // Expiry already excludes a same-cycle ack, so ack wins.
         if (timer_exp) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_ind <= 1'b0;
            mem_err <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (instr_valid) begin
                     cls      <= acc_cls;
                     dr_lat   <= dr_in;
                     exec_cnt <= '0;
                     case (acc_cls)
                        CLS_ALU, CLS_LEA: state <= S_EXEC;
                        CLS_LOAD: begin
                           state   <= S_MEM_RD;
                           mem_req <= 1'b1;
                        end
                        CLS_LOAD_IND, CLS_STORE_IND: begin
                           state   <= S_IND_RD;
                           mem_req <= 1'b1;
                           mem_ind <= 1'b1;
                        end
                        CLS_STORE: begin
                           state   <= S_MEM_WR;
                           mem_req <= 1'b1;
                           mem_we  <= 1'b1;
                        end
                        default: state <= S_IDLE;
                     endcase
                  end
               end
               S_EXEC: begin
                  if (exec_cnt == EXW'(EXEC_LAT - 1)) begin
                     state            <= S_WB;
                     enable_writeback <= 1'b1;
                     w_control        <= wb_source(cls);
                     dr               <= dr_lat;
                  end else begin
                     exec_cnt <= exec_cnt + EXW'(1);
                  end
               end
               S_IND_RD: begin
                  // Pointer fetched; mem_req stays high into the second access.
                  if (mem_ack) begin
                     mem_ind <= 1'b0;
                     if (cls == CLS_LOAD_IND) begin
                        state <= S_MEM_RD;
                     end else begin
                        state  <= S_MEM_WR;
                        mem_we <= 1'b1;
                     end
                  end
               end
               S_MEM_RD: begin
                  if (mem_ack) begin
                     state            <= S_WB;
                     mem_req          <= 1'b0;
                     enable_writeback <= 1'b1;
                     w_control        <= wb_source(cls);
                     dr               <= dr_lat;
                  end
               end
               S_MEM_WR: begin
                  if (mem_ack) begin
                     state   <= S_IDLE;
                     mem_req <= 1'b0;
                     mem_we  <= 1'b0;
                  end
               end
               S_WB: begin
                  state    <= S_IDLE;
                  wb_count <= wb_count + CNTW'(1);
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lc3_writeback_controller.sv
// Scoreboard bench for lc3_writeback_controller: directed instructions push
// expected writebacks; negedge monitors pop and compare.
module tb_lc3_writeback_controller;

   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_LD  = 4'b0010;
   localparam logic [3:0] OP_ST  = 4'b0011;
   localparam logic [3:0] OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STI = 4'b1011;
   localparam logic [3:0] OP_LEA = 4'b1110;

   typedef struct packed {
      logic [1:0] wc;
      logic [2:0] dr;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst, rst_b;
   logic        instr_valid, instr_valid_b;
   logic [3:0]  opcode;
   logic [2:0]  dr_in;
   logic        mem_ack;

   logic        instr_ready, mem_req, mem_we, mem_ind, ewb, mem_err;
   logic [1:0]  w_control;
   logic [2:0]  dr;
   logic [15:0] wb_count;

   logic        instr_ready_b, mem_req_b, mem_we_b, mem_ind_b, ewb_b, mem_err_b;
   logic [1:0]  w_control_b;
   logic [2:0]  dr_b;
   logic [15:0] wb_count_b;

   int  checks = 0;
   int  errors = 0;
   int  err_exp = 0;
   int  ack_cnt = 0;
   wb_t q_a[$];
   wb_t q_b[$];

   always #5 clk = ~clk;

   lc3_writeback_controller #(.EXEC_LAT(1), .MEM_TIMEOUT(16)) dut_a (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .dr_in(dr_in), .mem_ack(mem_ack), .mem_req(mem_req),
      .mem_we(mem_we), .mem_ind(mem_ind), .enable_writeback(ewb),
      .w_control(w_control), .dr(dr), .mem_err(mem_err), .wb_count(wb_count)
   );

   lc3_writeback_controller #(.EXEC_LAT(4), .MEM_TIMEOUT(16)) dut_b (
      .clk(clk), .rst(rst_b), .instr_valid(instr_valid_b), .instr_ready(instr_ready_b),
      .opcode(opcode), .dr_in(dr_in), .mem_ack(1'b0), .mem_req(mem_req_b),
      .mem_we(mem_we_b), .mem_ind(mem_ind_b), .enable_writeback(ewb_b),
      .w_control(w_control_b), .dr(dr_b), .mem_err(mem_err_b), .wb_count(wb_count_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Writeback / error monitors for both instances.
   always @(negedge clk) begin
      wb_t e;
      if (mem_ack && mem_req) ack_cnt++;
      if (ewb) begin
         if (q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_a_unexpected: got strobe dr=%0d expected none", dr);
         end else begin
            e = q_a.pop_front();
            check("wb_a_wc", 32'(w_control), 32'(e.wc));
            check("wb_a_dr", 32'(dr), 32'(e.dr));
         end
      end
      if (ewb_b) begin
         if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_b_unexpected: got strobe dr=%0d expected none", dr_b);
         end else begin
            e = q_b.pop_front();
            check("wb_b_wc", 32'(w_control_b), 32'(e.wc));
            check("wb_b_dr", 32'(dr_b), 32'(e.dr));
         end
      end
      if (mem_err) begin
         checks++;
         if (err_exp == 0) begin
            errors++;
            $display("FAIL mem_err_a_unexpected: got 1 expected 0");
         end else begin
            err_exp--;
         end
      end
      if (mem_err_b) begin
         checks++; errors++;
         $display("FAIL mem_err_b_unexpected: got 1 expected 0");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int acks0;
      logic [3:0] ops [4];
      ops = '{4'b0000, 4'b1100, 4'b1101, 4'b1111};

      rst = 1'b1; rst_b = 1'b1;
      instr_valid = 1'b0; instr_valid_b = 1'b0;
      opcode = '0; dr_in = '0; mem_ack = 1'b0;
      tick(); tick();
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_ewb", 32'(ewb), 32'd0);
      check("rst_wb_count", 32'(wb_count), 32'd0);
      check("rst_dr_wc", 32'({dr, w_control}), 32'd0);
      check("rst_ready_low", 32'(instr_ready), 32'd0);
      rst = 1'b0; rst_b = 1'b0;
      #1;
      check("ready_after_rst", 32'(instr_ready), 32'd1);

      // ADD dr=3, EXEC_LAT=1
      instr_valid = 1'b1; opcode = OP_ADD; dr_in = 3'd3;
      q_a.push_back('{wc: 2'd0, dr: 3'd3});
      tick();
      instr_valid = 1'b0;
      check("add_n1_ewb", 32'(ewb), 32'd0);
      tick();
      check("add_n2_ewb", 32'(ewb), 32'd1);
      check("add_n2_ready", 32'(instr_ready), 32'd0);
      tick();
      check("add_n3_ewb", 32'(ewb), 32'd0);
      check("add_n3_ready", 32'(instr_ready), 32'd1);
      check("add_wb_count", 32'(wb_count), 32'd1);

      // LDI dr=5, two wait cycles before each ack
      instr_valid = 1'b1; opcode = OP_LDI; dr_in = 3'd5;
      q_a.push_back('{wc: 2'd1, dr: 3'd5});
      acks0 = ack_cnt;
      tick();
      instr_valid = 1'b0;
      check("ldi_req1", 32'({mem_req, mem_ind, mem_we}), 32'b110);
      tick(); tick();
      check("ldi_req1_held", 32'({mem_req, mem_ind}), 32'b11);
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      check("ldi_req2", 32'({mem_req, mem_ind, mem_we}), 32'b100);
      tick(); tick();
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      check("ldi_wb", 32'({ewb, mem_req}), 32'b10);
      check("ldi_acks", 32'(ack_cnt - acks0), 32'd2);
      tick();
      check("ldi_wb_count", 32'(wb_count), 32'd2);
      check("ldi_ready", 32'(instr_ready), 32'd1);

      // STI then ST: no writebacks
      instr_valid = 1'b1; opcode = OP_STI; dr_in = 3'd4;
      tick();
      instr_valid = 1'b0;
      check("sti_ind", 32'({mem_req, mem_ind, mem_we}), 32'b110);
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      check("sti_wr", 32'({mem_req, mem_ind, mem_we}), 32'b101);
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      check("sti_done", 32'({mem_req, mem_we, instr_ready}), 32'b001);
      instr_valid = 1'b1; opcode = OP_ST;
      tick();
      instr_valid = 1'b0;
      check("st_wr", 32'({mem_req, mem_ind, mem_we}), 32'b101);
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      check("st_done", 32'({mem_req, mem_we}), 32'b00);
      check("store_wb_count", 32'(wb_count), 32'd2);

      // LD with no ack: timeout after 16 request cycles
      instr_valid = 1'b1; opcode = OP_LD; dr_in = 3'd1;
      err_exp++;
      tick();
      instr_valid = 1'b0;
      n = 0;
      while (mem_req && n < 40) begin
         n++;
         tick();
      end
      check("ld_timeout_req_cycles", 32'(n), 32'd16);
      check("ld_timeout_err", 32'({mem_err, instr_ready, ewb}), 32'b110);
      tick();
      check("ld_timeout_err_pulse", 32'(mem_err), 32'd0);
      check("ld_timeout_wb_count", 32'(wb_count), 32'd2);

      // Non-writeback opcodes back-to-back
      instr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         opcode = ops[i];
         check("nop_ready", 32'(instr_ready), 32'd1);
         tick();
         check("nop_quiet", 32'({mem_req, ewb, instr_ready}), 32'b001);
      end
      instr_valid = 1'b0;

      // EXEC_LAT=4: LEA aborted by reset, then ADD completes
      instr_valid_b = 1'b1; opcode = OP_LEA; dr_in = 3'd7;
      tick();
      instr_valid_b = 1'b0;
      tick();
      rst_b = 1'b1; tick(); rst_b = 1'b0;
      #1;
      check("b_rst_outs", 32'({ewb_b, mem_req_b, mem_we_b, mem_ind_b, mem_err_b, dr_b, w_control_b}), 32'd0);
      check("b_rst_count", 32'(wb_count_b), 32'd0);
      check("b_rst_ready", 32'(instr_ready_b), 32'd1);
      repeat (6) tick();
      instr_valid_b = 1'b1; opcode = OP_ADD; dr_in = 3'd2;
      q_b.push_back('{wc: 2'd0, dr: 3'd2});
      tick();
      instr_valid_b = 1'b0;
      repeat (3) tick();
      check("b_add_not_yet", 32'(ewb_b), 32'd0);
      tick();
      check("b_add_wb", 32'(ewb_b), 32'd1);
      tick();
      check("b_add_count", 32'(wb_count_b), 32'd1);
      check("b_add_ready", 32'(instr_ready_b), 32'd1);

      tick(); tick();
      check("q_a_drained", 32'(q_a.size()), 32'd0);
      check("q_b_drained", 32'(q_b.size()), 32'd0);
      check("err_drained", 32'(err_exp), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc3_writeback_controller.md
Name: lc3_writeback_controller

Overview:
Sequences the LC3 writeback stage. It accepts one decoded instruction at a time and runs execute-latency and memory-read phases, including the two-read LDI indirect phase. It then issues exactly one cycle of enable_writeback with the matching w_control and dr to the writeback datapath. It sits between decode/execute and the writeback stage, alongside the memory access port.

Parameters:
EXEC_LAT, 1, execute-stage cycles before ALU/LEA result is valid (1..7)
MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ack before abort (2..255)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
instr_valid  input  1  decoded instruction offered
instr_ready  output  1  controller can accept (IDLE only)
opcode  input  4  LC3 opcode of offered instruction
dr_in  input  3  destination register of offered instruction
mem_ack  input  1  memory access complete
mem_req  output  1  memory access request, held until ack/timeout
mem_we  output  1  1 = store access, 0 = read
mem_ind  output  1  current read is indirect pointer fetch (LDI/STI first read)
enable_writeback  output  1  one-cycle writeback strobe
w_control  output  2  writeback source select
dr  output  3  writeback destination register
mem_err  output  1  one-cycle pulse on memory timeout abort
wb_count  output  16  count of writeback strobes, wraps at 0xFFFF->0

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- rst high at a clk edge: state=IDLE, counters cleared, all registered outputs 0 (mem_req, mem_we, mem_ind, enable_writeback, w_control=0, dr=0, mem_err, wb_count).
- instr_ready = (state==IDLE) && !rst.
- Accept on instr_valid && instr_ready. Latch opcode and dr_in.
- States: IDLE, EXEC, IND_RD, MEM_RD, MEM_WR, WB.
- ADD(0001)/AND(0101)/NOT(1001): IDLE->EXEC for EXEC_LAT cycles->WB with w_control=WB_ALU.
- LEA(1110): same path with w_control=WB_PC.
- LD(0010)/LDR(0110): IDLE->MEM_RD->WB with w_control=WB_MEM.
- LDI(1010): IDLE->IND_RD (mem_ind=1)->MEM_RD->WB.
- ST(0011)/STR(0111): IDLE->MEM_WR (mem_we=1)->IDLE, with no writeback.
- STI(1011): IDLE->IND_RD->MEM_WR->IDLE.
- All other opcodes (BR, JMP, JSR, RTI, TRAP, 1101 reserved): consumed in the accept cycle, remain IDLE, no outputs.
- Memory states:
  - mem_req=1 from the first cycle in state until the cycle mem_ack is sampled high.
  - Transition on the edge where mem_ack=1; the next state's mem_req reasserts the following cycle if needed.
  - mem_ack while mem_req=0 is ignored.
- Timeout:
  - A per-access wait counter resets on entry to each memory state.
  - If MEM_TIMEOUT cycles elapse without ack: go to IDLE, pulse mem_err one cycle, no writeback.
  - Ack in the same cycle as expiry: ack wins.
- WB: exactly one cycle with enable_writeback=1, w_control and dr valid in that same cycle. wb_count increments at the end of that cycle. WB->IDLE.
- Outside WB, enable_writeback=0 and dr/w_control hold their last values.
- Latency, accept at cycle N:
  - ALU/LEA: enable_writeback at N+EXEC_LAT+1; instr_ready returns at N+EXEC_LAT+2.
  - LD with ack in first request cycle: mem_req at N+1, WB at N+2.
- Reset mid-operation: the abort is immediate. Any in-progress mem_req drops the next cycle, and no writeback is issued for the aborted instruction.

Decomposition:
- Shared package lc3_wb_ctrl_pkg holds:
  - LC3 opcode constants.
  - w_control encodings: WB_ALU=2'd0, WB_MEM=2'd1, WB_PC=2'd2 (2'd3 reserved, never driven).
  - State enum typedef.
  - Function classifying an opcode into {ALU, LEA, LOAD, LOAD_IND, STORE, STORE_IND, NONE}.
- One natural sub-module, lc3_mem_wait_timer: wait counter plus timeout compare, with a start/ack/expired interface.

Test Plan:
- EXEC_LAT=1: ADD with dr_in=3 accepted at cycle 10 -> enable_writeback=1, w_control=0, dr=3 at cycle 12 only; wb_count=1; instr_ready=1 at cycle 13.
- LDI with dr_in=5, mem_ack after 2 wait cycles per read -> mem_ind=1 during the first request, then mem_ind=0 on the second -> WB with w_control=1, dr=5; exactly 2 acks consumed.
- STI then ST -> mem_we=0 then 1 for STI, mem_we=1 for ST; enable_writeback never asserts; wb_count unchanged.
- LD with mem_ack never asserted, MEM_TIMEOUT=16 -> mem_req high 16 cycles, then mem_err pulse, no WB, instr_ready=1 next cycle.
- LEA with dr_in=7, rst pulsed during EXEC with EXEC_LAT=4 -> no enable_writeback, all outputs 0; a following ADD writes normally.
- Opcodes 0000/1100/1101/1111 back-to-back with instr_valid held -> one accepted per cycle; mem_req and enable_writeback stay 0.
